// File: rtl/imem_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : imem_arbiter
// Description : Two-requester (fetch / LSU) arbiter for the instruction ROM
//               read port. It has a bounded-starvation fixed priority and a
//               registered one-cycle response.
//               Optional conflict counter: define IMEM_ARB_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// =============================================================================

package memory_pkg;
    parameter int unsigned INSTR_MEM_SIZE_BYTES = 4096;
endpackage

module imem_arbiter #(
    parameter int unsigned MEM_SIZE_BYTES = memory_pkg::INSTR_MEM_SIZE_BYTES,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_req_i,
    input  logic [31:0] fetch_addr_i,
    output logic        fetch_gnt_o,
    output logic        fetch_rvalid_o,
    output logic [31:0] fetch_rdata_o,
    output logic        fetch_err_o,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] conflict_cnt_o
);

    localparam logic [3:0]  C_STARVE_LIMIT = 4'(STARVE_LIMIT);
    localparam logic [32:0] C_MEM_SIZE     = 33'(MEM_SIZE_BYTES);

    logic [3:0]  starve_q, starve_d;
    logic        fetch_rvalid_q, data_rvalid_q;
    logic        fetch_err_q, data_err_q;
    logic [31:0] fetch_rdata_q, data_rdata_q;

    logic        w_fetch_bad, w_data_bad;
    logic        w_data_wins;
    logic        w_fetch_gnt, w_data_gnt;

    // 33-bit compare so a ROM filling the whole 32-bit space does not wrap to 0
    assign w_fetch_bad = (fetch_addr_i[1:0] != 2'b00) || ({1'b0, fetch_addr_i} >= C_MEM_SIZE);
    assign w_data_bad  = (data_addr_i[1:0]  != 2'b00) || ({1'b0, data_addr_i}  >= C_MEM_SIZE);

    assign w_data_wins = data_req_i && (!fetch_req_i || (starve_q == C_STARVE_LIMIT));
    assign w_fetch_gnt = !rst_i && fetch_req_i && !w_data_wins;
    assign w_data_gnt  = !rst_i && w_data_wins;

    assign fetch_gnt_o = w_fetch_gnt;
    assign data_gnt_o  = w_data_gnt;

    always_comb begin
        mem_addr_o = 32'd0;
        if (w_fetch_gnt && !w_fetch_bad) begin
            mem_addr_o = fetch_addr_i;
        end else if (w_data_gnt && !w_data_bad) begin
            mem_addr_o = data_addr_i;
        end
    end

    // Counts fetch wins over a waiting LSU; any cycle without an LSU request restarts it
    always_comb begin
        starve_d = 4'd0;
        if (data_req_i && w_fetch_gnt) begin
            starve_d = (starve_q == C_STARVE_LIMIT) ? starve_q : starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q       <= 4'd0;
            fetch_rvalid_q <= 1'b0;
            fetch_err_q    <= 1'b0;
            fetch_rdata_q  <= 32'd0;
            data_rvalid_q  <= 1'b0;
            data_err_q     <= 1'b0;
            data_rdata_q   <= 32'd0;
        end else begin
            starve_q       <= starve_d;
            fetch_rvalid_q <= w_fetch_gnt;
            fetch_err_q    <= w_fetch_gnt && w_fetch_bad;
            data_rvalid_q  <= w_data_gnt;
            data_err_q     <= w_data_gnt && w_data_bad;
            if (w_fetch_gnt) begin
                fetch_rdata_q <= w_fetch_bad ? 32'd0 : mem_rdata_i;
            end
            if (w_data_gnt) begin
                data_rdata_q <= w_data_bad ? 32'd0 : mem_rdata_i;
            end
        end
    end

    assign fetch_rvalid_o = fetch_rvalid_q;
    assign fetch_err_o    = fetch_err_q;
    assign fetch_rdata_o  = fetch_rdata_q;
    assign data_rvalid_o  = data_rvalid_q;
    assign data_err_o     = data_err_q;
    assign data_rdata_o   = data_rdata_q;

`ifdef IMEM_ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            conflict_cnt_q <= 32'd0;
        end else if (fetch_req_i && data_req_i) begin
            conflict_cnt_q <= conflict_cnt_q + 32'd1;
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
`else
    assign conflict_cnt_o = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : tb_imem_arbiter
// Description : Directed self-checking bench for imem_arbiter.
// Revision    : 1.0 - initial release
// =============================================================================

module tb_imem_arbiter;

    localparam int unsigned MEM_BYTES = 4096;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        fetch_req_i, data_req_i;
    logic [31:0] fetch_addr_i, data_addr_i;
    logic        fetch_gnt_o, fetch_rvalid_o, fetch_err_o;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] fetch_rdata_o, data_rdata_o;
    logic [31:0] mem_addr_o, mem_rdata_i, conflict_cnt_o;

    int vectors     = 0;
    int miscompares = 0;

    imem_arbiter #(
        .MEM_SIZE_BYTES (MEM_BYTES),
        .STARVE_LIMIT   (4)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .fetch_req_i    (fetch_req_i),
        .fetch_addr_i   (fetch_addr_i),
        .fetch_gnt_o    (fetch_gnt_o),
        .fetch_rvalid_o (fetch_rvalid_o),
        .fetch_rdata_o  (fetch_rdata_o),
        .fetch_err_o    (fetch_err_o),
        .data_req_i     (data_req_i),
        .data_addr_i    (data_addr_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .mem_addr_o     (mem_addr_o),
        .mem_rdata_i    (mem_rdata_i),
        .conflict_cnt_o (conflict_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // ROM model: every word is distinct and non-zero, including word 0
    function automatic logic [31:0] rom_word(input logic [9:0] idx);
        return 32'hC0DE_1000 + {22'd0, idx};
    endfunction

    assign mem_rdata_i = rom_word(mem_addr_o[11:2]);

    // Leaves time at rising edge + 1
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_i        = 1'b1;
        fetch_req_i  = 1'b0;
        data_req_i   = 1'b0;
        fetch_addr_i = 32'd0;
        data_addr_i  = 32'd0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i        = 1'b1;
        fetch_req_i  = 1'b1;
        data_req_i   = 1'b1;
        fetch_addr_i = 32'h4;
        data_addr_i  = 32'h8;
        #1;
        vectors++;
        if (fetch_gnt_o !== 1'b0 || data_gnt_o !== 1'b0 || mem_addr_o !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_gnt: fetch_gnt=%b data_gnt=%b mem_addr=%h, want 0 0 0",
                     fetch_gnt_o, data_gnt_o, mem_addr_o);
        end
        tick();
        vectors++;
        if (fetch_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0 || fetch_err_o !== 1'b0 ||
            data_err_o !== 1'b0 || fetch_rdata_o !== 32'd0 || data_rdata_o !== 32'd0 ||
            conflict_cnt_o !== 32'd0 || fetch_gnt_o !== 1'b0 || data_gnt_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: frv=%b drv=%b ferr=%b derr=%b frd=%h drd=%h cnt=%h fg=%b dg=%b, want all 0",
                     fetch_rvalid_o, data_rvalid_o, fetch_err_o, data_err_o,
                     fetch_rdata_o, data_rdata_o, conflict_cnt_o, fetch_gnt_o, data_gnt_o);
        end
        fetch_req_i = 1'b0;
        data_req_i  = 1'b0;
        rst_i       = 1'b0;
        tick();
    endtask

    task automatic test_fetch_stream();
        for (int k = 0; k < 3; k++) begin
            fetch_req_i  = 1'b1;
            fetch_addr_i = 32'(4 * k);
            #1;
            vectors++;
            if (fetch_gnt_o !== 1'b1 || data_gnt_o !== 1'b0 || mem_addr_o !== 32'(4 * k)) begin
                miscompares++;
                $display("FAIL fetch_gnt[%0d]: fetch_gnt=%b data_gnt=%b mem_addr=%h, want 1 0 %h",
                         k, fetch_gnt_o, data_gnt_o, mem_addr_o, 32'(4 * k));
            end
            tick();
            vectors++;
            if (fetch_rvalid_o !== 1'b1 || fetch_err_o !== 1'b0 || data_rvalid_o !== 1'b0 ||
                fetch_rdata_o !== rom_word(10'(k))) begin
                miscompares++;
                $display("FAIL fetch_resp[%0d]: rvalid=%b err=%b drvalid=%b rdata=%h, want 1 0 0 %h",
                         k, fetch_rvalid_o, fetch_err_o, data_rvalid_o, fetch_rdata_o, rom_word(10'(k)));
            end
        end
        fetch_req_i = 1'b0;
        #1;
        vectors++;
        if (mem_addr_o !== 32'd0 || fetch_gnt_o !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_addr: mem_addr=%h fetch_gnt=%b, want 0 0", mem_addr_o, fetch_gnt_o);
        end
        tick();
        vectors++;
        if (fetch_rvalid_o !== 1'b0 || fetch_rdata_o !== rom_word(10'd2)) begin
            miscompares++;
            $display("FAIL idle_resp: rvalid=%b rdata=%h, want 0 %h", fetch_rvalid_o, fetch_rdata_o, rom_word(10'd2));
        end
    endtask

    task automatic test_starvation();
        logic exp_d;
        fetch_req_i  = 1'b1;
        data_req_i   = 1'b1;
        fetch_addr_i = 32'h10;
        data_addr_i  = 32'h20;
        for (int c = 0; c < 10; c++) begin
            exp_d = (c == 4) || (c == 9);
            #1;
            vectors++;
            if (data_gnt_o !== exp_d || fetch_gnt_o !== ~exp_d) begin
                miscompares++;
                $display("FAIL starve_gnt[%0d]: fetch_gnt=%b data_gnt=%b, want %b %b",
                         c, fetch_gnt_o, data_gnt_o, ~exp_d, exp_d);
            end
            tick();
            vectors++;
            if (data_rvalid_o !== exp_d || fetch_rvalid_o !== ~exp_d) begin
                miscompares++;
                $display("FAIL starve_rvalid[%0d]: fetch_rvalid=%b data_rvalid=%b, want %b %b",
                         c, fetch_rvalid_o, data_rvalid_o, ~exp_d, exp_d);
            end
            if (exp_d) begin
                vectors++;
                if (data_rdata_o !== rom_word(10'd8) || fetch_rdata_o !== rom_word(10'd4)) begin
                    miscompares++;
                    $display("FAIL starve_rdata[%0d]: data_rdata=%h fetch_rdata=%h, want %h %h (fetch held)",
                             c, data_rdata_o, fetch_rdata_o, rom_word(10'd8), rom_word(10'd4));
                end
            end
        end
        fetch_req_i = 1'b0;
        data_req_i  = 1'b0;
        tick();
    endtask

    task automatic test_error();
        logic [31:0] addrs [3];
        logic        bad   [3];
        addrs[0] = 32'h6;            bad[0] = 1'b1;
        addrs[1] = 32'(MEM_BYTES);   bad[1] = 1'b1;
        addrs[2] = 32'hC;            bad[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            data_req_i  = 1'b1;
            data_addr_i = addrs[k];
            #1;
            vectors++;
            if (data_gnt_o !== 1'b1 || mem_addr_o !== (bad[k] ? 32'd0 : addrs[k])) begin
                miscompares++;
                $display("FAIL err_gnt[%0d]: data_gnt=%b mem_addr=%h, want 1 %h",
                         k, data_gnt_o, mem_addr_o, bad[k] ? 32'd0 : addrs[k]);
            end
            tick();
            vectors++;
            if (data_rvalid_o !== 1'b1 || data_err_o !== bad[k] ||
                data_rdata_o !== (bad[k] ? 32'd0 : rom_word(10'd3))) begin
                miscompares++;
                $display("FAIL err_resp[%0d]: rvalid=%b err=%b rdata=%h, want 1 %b %h",
                         k, data_rvalid_o, data_err_o, data_rdata_o, bad[k],
                         bad[k] ? 32'd0 : rom_word(10'd3));
            end
        end
        data_req_i   = 1'b0;
        fetch_req_i  = 1'b1;
        fetch_addr_i = 32'h2;
        #1;
        vectors++;
        if (fetch_gnt_o !== 1'b1 || mem_addr_o !== 32'd0) begin
            miscompares++;
            $display("FAIL ferr_gnt: fetch_gnt=%b mem_addr=%h, want 1 0", fetch_gnt_o, mem_addr_o);
        end
        tick();
        vectors++;
        if (fetch_rvalid_o !== 1'b1 || fetch_err_o !== 1'b1 || fetch_rdata_o !== 32'd0 || data_err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL ferr_resp: rvalid=%b err=%b rdata=%h derr=%b, want 1 1 0 0",
                     fetch_rvalid_o, fetch_err_o, fetch_rdata_o, data_err_o);
        end
        fetch_req_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic exp_d;
        fetch_req_i  = 1'b1;
        data_req_i   = 1'b1;
        fetch_addr_i = 32'h14;
        data_addr_i  = 32'h18;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (fetch_gnt_o !== 1'b1) begin
                miscompares++;
                $display("FAIL rstmid_pre[%0d]: fetch_gnt=%b, want 1", c, fetch_gnt_o);
            end
            tick();
        end
        #1;
        rst_i = 1'b1;
        #1;
        vectors++;
        if (fetch_gnt_o !== 1'b0 || data_gnt_o !== 1'b0 || mem_addr_o !== 32'd0 ||
            fetch_rvalid_o !== 1'b0 || fetch_rdata_o !== 32'd0 || data_rdata_o !== 32'd0 ||
            conflict_cnt_o !== 32'd0) begin
            miscompares++;
            $display("FAIL rstmid_async: fg=%b dg=%b addr=%h frv=%b frd=%h drd=%h cnt=%h, want all 0",
                     fetch_gnt_o, data_gnt_o, mem_addr_o, fetch_rvalid_o, fetch_rdata_o,
                     data_rdata_o, conflict_cnt_o);
        end
        tick();
        vectors++;
        if (fetch_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_drop: fetch_rvalid=%b data_rvalid=%b, want 0 0", fetch_rvalid_o, data_rvalid_o);
        end
        rst_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            exp_d = (c == 4);
            #1;
            vectors++;
            if (data_gnt_o !== exp_d || fetch_gnt_o !== ~exp_d) begin
                miscompares++;
                $display("FAIL rstmid_starve[%0d]: fetch_gnt=%b data_gnt=%b, want %b %b",
                         c, fetch_gnt_o, data_gnt_o, ~exp_d, exp_d);
            end
            tick();
        end
        fetch_req_i = 1'b0;
        data_req_i  = 1'b0;
        tick();
    endtask

    task automatic test_starve_restart();
        logic exp_d;
        fetch_req_i  = 1'b1;
        fetch_addr_i = 32'h24;
        data_addr_i  = 32'h28;
        // 3 losses, one idle LSU cycle, then 4 more losses before the LSU wins
        for (int c = 0; c < 9; c++) begin
            data_req_i = (c != 3);
            exp_d      = (c == 8);
            #1;
            vectors++;
            if (data_gnt_o !== exp_d || fetch_gnt_o !== ~exp_d) begin
                miscompares++;
                $display("FAIL restart_gnt[%0d]: fetch_gnt=%b data_gnt=%b, want %b %b",
                         c, fetch_gnt_o, data_gnt_o, ~exp_d, exp_d);
            end
            tick();
        end
        fetch_req_i = 1'b0;
        data_req_i  = 1'b0;
        tick();
    endtask

    task automatic test_conflict_cnt();
        logic [31:0] exp_cnt;
`ifdef IMEM_ARB_PERF_CNT_EN
        exp_cnt = 32'd10;
`else
        exp_cnt = 32'd0;
`endif
        apply_reset();
        vectors++;
        if (conflict_cnt_o !== 32'd0) begin
            miscompares++;
            $display("FAIL cnt_reset: conflict_cnt=%0d, want 0", conflict_cnt_o);
        end
        fetch_req_i  = 1'b1;
        data_req_i   = 1'b1;
        fetch_addr_i = 32'h0;
        data_addr_i  = 32'h4;
        for (int c = 0; c < 10; c++) begin
            tick();
        end
        fetch_req_i = 1'b0;
        tick();
        tick();
        vectors++;
        if (conflict_cnt_o !== exp_cnt) begin
            miscompares++;
            $display("FAIL cnt_value: conflict_cnt=%0d, want %0d", conflict_cnt_o, exp_cnt);
        end
        data_req_i = 1'b0;
        tick();
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_fetch_stream();
        test_starvation();
        test_error();
        test_reset_mid();
        test_starve_restart();
        test_conflict_cnt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
